// File: rtl/freq_ctrl_pkg.sv
`default_nettype none
// freq_ctrl_pkg: shared state encoding and BCD constants for the frequency-counter sequencer.
package freq_ctrl_pkg;

  typedef enum logic [1:0] {
    S_COUNT = 2'd0,
    S_TENS  = 2'd1,
    S_UNITS = 2'd2,
    S_LOAD  = 2'd3
  } state_t;

  localparam int         BCD_MAX     = 9;
  localparam int         DIV         = 10;
  localparam logic [3:0] BLANK_DIGIT = 4'hF;

endpackage
`default_nettype wire

// File: rtl/freq_gate_controller_edge_sync.sv
`default_nettype none
// edge_sync: two-flop synchroniser for an asynchronous pad plus rising-edge pulse detector.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic meta;
  logic q1;
  logic q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q1   <= 1'b0;
      q2   <= 1'b0;
    end else begin
      meta <= din;
      q1   <= meta;
      q2   <= q1;
    end
  end

  assign pulse = q1 & ~q2;

endmodule
`default_nettype wire

// File: rtl/freq_gate_controller.sv
`default_nettype none
// freq_gate_controller: counts pad edges over a gate window, converts to two BCD digits, strobes load.
// Build option FREQ_CTRL_BLANK_EN: on overflow publish 4'hF digits instead of saturating to 99.
module freq_gate_controller
  import freq_ctrl_pkg::*;
#(
  parameter int UPDATE_PERIOD = 1200,
  parameter int CNT_W         = 7,
  parameter int PER_W         = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             signal,
  input  logic             period_load,
  input  logic [PER_W-1:0] period,
  output logic             load,
  output logic [3:0]       ten_count,
  output logic [3:0]       unit_count,
  output logic             overflow,
  output logic             busy
);

  state_t           state;
  logic [PER_W-1:0] clk_cnt;
  logic [PER_W-1:0] gate_reg;
  logic [PER_W-1:0] gate_act;
  logic [PER_W-1:0] period_fixed;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_next;
  logic [CNT_W-1:0] work;
  logic [CNT_W-1:0] tens;
  logic [3:0]       units;
  logic             edge_pulse;
  logic             window_end;
  logic             over;

  edge_sync u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .din   (signal),
    .pulse (edge_pulse)
  );

  assign period_fixed = (period == '0) ? PER_W'(1) : period;
  assign window_end   = (clk_cnt == gate_act - PER_W'(1));
  assign edge_next    = (edge_pulse && (edge_cnt != '1)) ? edge_cnt + CNT_W'(1) : edge_cnt;
  assign over         = (tens > CNT_W'(BCD_MAX));

  // gate_act is the window length in force; gate_reg only becomes active on S_COUNT entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_COUNT;
      clk_cnt    <= '0;
      edge_cnt   <= '0;
      work       <= '0;
      tens       <= '0;
      units      <= '0;
      gate_reg   <= PER_W'(UPDATE_PERIOD);
      gate_act   <= PER_W'(UPDATE_PERIOD);
      load       <= 1'b0;
      ten_count  <= 4'd0;
      unit_count <= 4'd0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      load <= 1'b0;
      if (period_load) begin
        gate_reg <= period_fixed;
      end

      case (state)
        S_COUNT: begin
          edge_cnt <= edge_next;
          if (window_end) begin
            clk_cnt <= '0;
            work    <= edge_next;
            busy    <= 1'b1;
            state   <= S_TENS;
          end else begin
            clk_cnt <= clk_cnt + PER_W'(1);
          end
        end

        S_TENS: begin
          if (work >= CNT_W'(DIV)) begin
            work <= work - CNT_W'(DIV);
            tens <= tens + CNT_W'(1);
          end else begin
            state <= S_UNITS;
          end
        end

        S_UNITS: begin
          units <= work[3:0];
          state <= S_LOAD;
        end

        S_LOAD: begin
          load     <= 1'b1;
          overflow <= over;
          if (over) begin
`ifdef FREQ_CTRL_BLANK_EN
            ten_count  <= BLANK_DIGIT;
            unit_count <= BLANK_DIGIT;
`else
            ten_count  <= 4'(BCD_MAX);
            unit_count <= 4'(BCD_MAX);
`endif
          end else begin
            ten_count  <= tens[3:0];
            unit_count <= units;
          end
          edge_cnt <= '0;
          work     <= '0;
          tens     <= '0;
          units    <= '0;
          // A strobe landing on this cycle is honoured immediately rather than a window late.
          gate_act <= period_load ? period_fixed : gate_reg;
          busy     <= 1'b0;
          state    <= S_COUNT;
        end

        default: begin
          state <= S_COUNT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_gate_controller.sv
`default_nettype none
// tb_freq_gate_controller: directed self-checking bench for the gated frequency counter.
module tb_freq_gate_controller;

  localparam int GATE0 = 100;

`ifdef FREQ_CTRL_BLANK_EN
  localparam logic [3:0] OVF_TEN  = 4'hF;
  localparam logic [3:0] OVF_UNIT = 4'hF;
`else
  localparam logic [3:0] OVF_TEN  = 4'd9;
  localparam logic [3:0] OVF_UNIT = 4'd9;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        signal;
  logic        period_load;
  logic [11:0] period;
  logic        load;
  logic [3:0]  ten_count;
  logic [3:0]  unit_count;
  logic        overflow;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  freq_gate_controller #(
    .UPDATE_PERIOD (GATE0),
    .CNT_W         (7),
    .PER_W         (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .signal      (signal),
    .period_load (period_load),
    .period      (period),
    .load        (load),
    .ten_count   (ten_count),
    .unit_count  (unit_count),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Called on the negedge of frame cycle 0; runs one frame and returns its length (-1 on timeout).
  // Stimulus per cycle c: toggle while c<tog, else pulses high at even c in [2,2+2*np) and at x1/x2.
  task automatic next_load(input int pl_at, input int pl_val, input int np, input int tog,
                           input int x1, input int x2, output int len, output int busy_cnt);
    len      = -1;
    busy_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      period_load = (c == pl_at);
      if (c == pl_at) period = 12'(pl_val);
      if (c < tog) signal = ~signal;
      else signal = (c >= 2 && c < 2 + 2 * np && (c % 2) == 0) || c == x1 || c == x2;
      @(negedge clk);
      if (load) begin
        len = c + 1;
        break;
      end
      if (busy) busy_cnt++;
    end
    period_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (load !== 1'b0) begin failures++; $display("FAIL rst_load got=%b exp=0", load); end
    checks++; if (ten_count !== 4'd0) begin failures++; $display("FAIL rst_ten got=%h exp=0", ten_count); end
    checks++; if (unit_count !== 4'd0) begin failures++; $display("FAIL rst_unit got=%h exp=0", unit_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_measure();
    int len, bc;
    next_load(-1, 0, 37, 0, -1, -1, len, bc);
    checks++; if (len !== 106) begin failures++; $display("FAIL m37_len got=%0d exp=106", len); end
    checks++; if (ten_count !== 4'd3) begin failures++; $display("FAIL m37_ten got=%h exp=3", ten_count); end
    checks++; if (unit_count !== 4'd7) begin failures++; $display("FAIL m37_unit got=%h exp=7", unit_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL m37_ovf got=%b exp=0", overflow); end
    checks++; if (bc !== 6) begin failures++; $display("FAIL m37_busy_cycles got=%0d exp=6", bc); end
  endtask

  task automatic test_no_edges();
    int len, bc;
    for (int f = 0; f < 2; f++) begin
      next_load(-1, 0, 0, 0, -1, -1, len, bc);
      checks++; if (len !== 103) begin failures++; $display("FAIL idle%0d_len got=%0d exp=103", f, len); end
      checks++;
      if (ten_count !== 4'd0 || unit_count !== 4'd0 || overflow !== 1'b0) begin
        failures++;
        $display("FAIL idle%0d_digits got=%h%h ovf=%b exp=00 ovf=0", f, ten_count, unit_count, overflow);
      end
    end
  endtask

  task automatic test_overflow();
    int len, bc;
    next_load(1, 300, 0, 0, -1, -1, len, bc);
    checks++; if (len !== 103) begin failures++; $display("FAIL ovf_pre_len got=%0d exp=103", len); end
    // 145 rises saturate the counter at 127: 12 tens steps
    next_load(-1, 0, 0, 290, -1, -1, len, bc);
    checks++; if (len !== 315) begin failures++; $display("FAIL ovf_len got=%0d exp=315", len); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (ten_count !== OVF_TEN) begin failures++; $display("FAIL ovf_ten got=%h exp=%h", ten_count, OVF_TEN); end
    checks++; if (unit_count !== OVF_UNIT) begin failures++; $display("FAIL ovf_unit got=%h exp=%h", unit_count, OVF_UNIT); end
    next_load(-1, 0, 12, 0, -1, -1, len, bc);
    checks++; if (len !== 304) begin failures++; $display("FAIL m12_len got=%0d exp=304", len); end
    checks++;
    if (ten_count !== 4'd1 || unit_count !== 4'd2 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL m12_digits got=%h%h ovf=%b exp=12 ovf=0", ten_count, unit_count, overflow);
    end
  endtask

  task automatic test_period();
    int len, bc;
    next_load(50, 20, 0, 0, -1, -1, len, bc);
    checks++; if (len !== 303) begin failures++; $display("FAIL per_old_len got=%0d exp=303", len); end
    next_load(-1, 0, 0, 0, -1, -1, len, bc);
    checks++; if (len !== 23) begin failures++; $display("FAIL per20_len got=%0d exp=23", len); end
    // strobe on the window's final cycle
    next_load(19, 7, 0, 0, -1, -1, len, bc);
    checks++; if (len !== 23) begin failures++; $display("FAIL per_end_len got=%0d exp=23", len); end
    next_load(-1, 0, 0, 0, -1, -1, len, bc);
    checks++; if (len !== 10) begin failures++; $display("FAIL per7_len got=%0d exp=10", len); end
    next_load(2, 0, 0, 0, -1, -1, len, bc);
    checks++; if (len !== 10) begin failures++; $display("FAIL per0_pre_len got=%0d exp=10", len); end
    for (int f = 0; f < 2; f++) begin
      next_load(-1, 0, 0, 0, -1, -1, len, bc);
      checks++; if (len !== 4) begin failures++; $display("FAIL per0_len%0d got=%0d exp=4", f, len); end
    end
  endtask

  task automatic test_window_edges();
    int len, bc;
    next_load(1, 20, 0, 0, -1, -1, len, bc);
    checks++; if (len !== 4) begin failures++; $display("FAIL we_pre_len got=%0d exp=4", len); end
    // rise at gate-3 lands on the last counting cycle
    next_load(-1, 0, 5, 0, 17, -1, len, bc);
    checks++; if (len !== 23) begin failures++; $display("FAIL we_last_len got=%0d exp=23", len); end
    checks++;
    if (ten_count !== 4'd0 || unit_count !== 4'd6) begin
      failures++; $display("FAIL we_last_digits got=%h%h exp=06", ten_count, unit_count);
    end
    checks++; if (bc !== 3) begin failures++; $display("FAIL we_busy_cycles got=%0d exp=3", bc); end
    // rises at gate-2 and gate arrive during conversion and must be dropped
    next_load(-1, 0, 5, 0, 18, 20, len, bc);
    checks++; if (len !== 23) begin failures++; $display("FAIL we_busy_len got=%0d exp=23", len); end
    checks++;
    if (ten_count !== 4'd0 || unit_count !== 4'd5) begin
      failures++; $display("FAIL we_busy_digits got=%h%h exp=05", ten_count, unit_count);
    end
  endtask

  task automatic test_reset_mid();
    int len, bc;
    for (int c = 0; c < 20; c++) begin
      signal = (c >= 2 && c < 12 && (c % 2) == 0);
      @(negedge clk);
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rm_in_tens_busy got=%b exp=1", busy); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (load !== 1'b0 || ten_count !== 4'd0 || unit_count !== 4'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rm_outputs got load=%b digits=%h%h ovf=%b busy=%b exp all 0",
               load, ten_count, unit_count, overflow, busy);
    end
    @(negedge clk);
    checks++; if (load !== 1'b0) begin failures++; $display("FAIL rm_load2 got=%b exp=0", load); end
    reset = 1'b0;
    next_load(-1, 0, 4, 0, -1, -1, len, bc);
    checks++; if (len !== 103) begin failures++; $display("FAIL rm_restart_len got=%0d exp=103", len); end
    checks++;
    if (ten_count !== 4'd0 || unit_count !== 4'd4) begin
      failures++; $display("FAIL rm_restart_digits got=%h%h exp=04", ten_count, unit_count);
    end
  endtask

  initial begin
    reset       = 1'b1;
    signal      = 1'b0;
    period_load = 1'b0;
    period      = 12'd0;
    test_reset();
    test_measure();
    test_no_edges();
    test_overflow();
    test_period();
    test_window_edges();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
